// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM states and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 9;
    localparam int IMMF_BIT = 7;
    localparam int RS_HI    = 6;
    localparam int RS_LO    = 4;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into control fields.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [2:0]         rd,
    output logic [2:0]         rs,
    output logic [7:0]         imm,
    output logic               is_load,
    output logic               is_add,
    output logic               is_jmp,
    output logic               is_out,
    output logic               is_halt
);

    logic [3:0] opcode;
    logic       unused_bits;

    assign opcode  = ir[OP_HI:OP_LO];
    assign rd      = ir[RD_HI:RD_LO];
    assign rs      = ir[RS_HI:RS_LO];
    assign imm     = ir[IMM_HI:IMM_LO];

    // Undefined opcodes fall through every flag and therefore behave as NOP.
    assign is_load = (opcode == OP_LOAD);
    assign is_add  = (opcode == OP_ADD);
    assign is_jmp  = (opcode == OP_JMP);
    assign is_out  = (opcode == OP_OUT);
    assign is_halt = (opcode == OP_HALT);

    assign unused_bits = ^{ir[8], ir};

endmodule

// File: rtl/instr_sequencer.sv
// Four-cycle FETCH/DECODE/EXEC/WB sequencer driving register-file and output strobes from a ROM program.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic [2:0]         rf_raddr_a,
    output logic [2:0]         rf_raddr_b,
    output logic [2:0]         rf_waddr,
    output logic               rf_we,
    output logic               rf_wsel,
    output logic [7:0]         imm,
    output logic               alu_bsel,
    output logic               out_we,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    state_t             state, next_state;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  pc_q;

    logic [2:0] d_rd, d_rs;
    logic [7:0] d_imm;
    logic       is_load, is_add, is_jmp, is_out, is_halt;

    instr_decode #(.INSTR_W(INSTR_W)) u_decode (
        .ir      (ir),
        .rd      (d_rd),
        .rs      (d_rs),
        .imm     (d_imm),
        .is_load (is_load),
        .is_add  (is_add),
        .is_jmp  (is_jmp),
        .is_out  (is_out),
        .is_halt (is_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc_q  <= '0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && run)
                ir <= rom_instr;
            if (state == S_WB && !is_halt)
                pc_q <= is_jmp ? ir[ADDR_W-1:0] : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Outputs decode from state and IR, both cleared by reset, so they drop to 0 with rst.
    always_comb begin
        next_state = state;
        rf_raddr_a = 3'd0;
        rf_raddr_b = 3'd0;
        rf_waddr   = 3'd0;
        rf_we      = 1'b0;
        rf_wsel    = 1'b0;
        imm        = 8'd0;
        alu_bsel   = 1'b0;
        out_we     = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                if (run)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                rf_raddr_a = d_rd;
                rf_raddr_b = d_rs;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                rf_raddr_a = d_rd;
                rf_raddr_b = d_rs;
                imm        = d_imm;
                rf_wsel    = is_load;
                alu_bsel   = is_add & d_imm[IMMF_BIT];
                next_state = S_WB;
            end
            S_WB: begin
                rf_raddr_a = d_rd;
                rf_raddr_b = d_rs;
                imm        = d_imm;
                rf_wsel    = is_load;
                alu_bsel   = is_add & d_imm[IMMF_BIT];
                rf_we      = is_load | is_add;
                rf_waddr   = (is_load | is_add) ? d_rd : 3'd0;
                out_we     = is_out;
                next_state = is_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign pc       = pc_q;
    assign rom_addr = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe events, a negedge monitor pops and checks them.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  rom_addr;
    logic [15:0] rom_instr;
    logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we, rf_wsel, alu_bsel, out_we, halted;
    logic [7:0]  imm;
    logic [3:0]  pc;

    logic [15:0] rom [16];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct packed {
        logic [15:0] cyc;
        logic        rf_we;
        logic        out_we;
        logic [2:0]  waddr;
        logic        wsel;
        logic [7:0]  imm;
        logic        bsel;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [3:0]  pc;
    } ev_t;

    ev_t sb [$];

    instr_sequencer #(.ADDR_W(4), .INSTR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .rom_addr   (rom_addr),
        .rom_instr  (rom_instr),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .imm        (imm),
        .alu_bsel   (alu_bsel),
        .out_we     (out_we),
        .halted     (halted),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    assign rom_instr = rom[rom_addr];

    // cyc is the number of the cycle in progress; cycle 1 is the first FETCH after release.
    always @(posedge clk) begin
        if (rst) cyc = 1;
        else     cyc = cyc + 1;
    end

    function automatic ev_t mk(int c, logic we, logic ow, logic [2:0] wa, logic ws,
                               logic [7:0] im, logic bs, logic [2:0] ra, logic [2:0] rb,
                               logic [3:0] p);
        ev_t e;
        e.cyc = c[15:0]; e.rf_we = we; e.out_we = ow; e.waddr = wa; e.wsel = ws;
        e.imm = im; e.bsel = bs; e.ra = ra; e.rb = rb; e.pc = p;
        return e;
    endfunction

    always @(negedge clk) begin
        ev_t act, exp_e;
        if (!rst) begin
            if (rf_we && out_we) begin
                checks++; failures++;
                $display("FAIL both_strobes cyc=%0d rf_we=1 out_we=1 required not both", cyc);
            end
            if (rf_we || out_we) begin
                act = mk(cyc, rf_we, out_we, rf_waddr, rf_wsel, imm, alu_bsel,
                         rf_raddr_a, rf_raddr_b, pc);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe got=%h required none", act);
                end else begin
                    exp_e = sb.pop_front();
                    if (act !== exp_e) begin
                        failures++;
                        $display("FAIL strobe_event got=%h required=%h", act, exp_e);
                    end
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic wait_cyc(int n);
        int guard = 0;
        while (cyc < n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++; failures++;
            $display("FAIL wait_cyc got=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_rom(input logic [15:0] fill);
        for (int i = 0; i < 16; i++) rom[i] = fill;
    endtask

    function automatic int outs();
        return int'({rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel, imm,
                     alu_bsel, out_we, halted, pc, rom_addr});
    endfunction

    initial begin
        load_rom(16'h0000);
        #12;
        chk("reset_outputs", outs(), 0);

        // LOAD r1,2 / ADD r1,r1 / OUT r1 / JMP 0
        rom[0] = 16'h1202; rom[1] = 16'h2210; rom[2] = 16'hF200; rom[3] = 16'hC000;
        sb.push_back(mk(4,  1, 0, 3'd1, 1, 8'h02, 0, 3'd1, 3'd0, 4'd0));
        sb.push_back(mk(8,  1, 0, 3'd1, 0, 8'h10, 0, 3'd1, 3'd1, 4'd1));
        sb.push_back(mk(12, 0, 1, 3'd0, 0, 8'h00, 0, 3'd1, 3'd0, 4'd2));
        run = 1'b1;
        do_reset();
        chk("t1_first_fetch_addr", int'(rom_addr), 0);
        wait_cyc(5);  chk("t1_pc_after_load", int'(pc), 1);
        wait_cyc(9);  chk("t1_pc_after_add", int'(pc), 2);
        wait_cyc(16); chk("t1_pc_during_jmp_wb", int'(pc), 3);
        wait_cyc(17); chk("t1_pc_after_jmp", int'(pc), 0);
        chk("t1_rom_addr_after_jmp", int'(rom_addr), 0);
        chk("t1_sb_empty", sb.size(), 0);

        // All-NOP program: 16 instructions, pc wraps, no strobes
        load_rom(16'h0000);
        do_reset();
        wait_cyc(61); chk("t2_pc_instr16", int'(pc), 15);
        wait_cyc(64); chk("t2_pc_last_wb", int'(pc), 15);
        wait_cyc(65); chk("t2_pc_wrapped", int'(pc), 0);
        chk("t2_rom_addr_wrapped", int'(rom_addr), 0);
        chk("t2_sb_empty", sb.size(), 0);

        // NOPs, ADD r2,#5 at 4, HALT at 5; run dropped in DECODE of instr 4
        load_rom(16'h0000);
        rom[4] = 16'h2485; rom[5] = 16'hE000;
        sb.push_back(mk(20, 1, 0, 3'd2, 0, 8'h85, 1, 3'd2, 3'd0, 4'd4));
        do_reset();
        wait_cyc(18);
        run = 1'b0;
        wait_cyc(22); chk("t3_hold_pc", int'(pc), 5);
        wait_cyc(23); chk("t3_hold_raddr_a", int'(rf_raddr_a), 0);
        wait_cyc(24);
        run = 1'b1;
        chk("t3_hold_not_halted", int'(halted), 0);
        wait_cyc(27); chk("t3_halt_wb_not_yet", int'(halted), 0);
        wait_cyc(28); chk("t3_halted", int'(halted), 1);
        chk("t3_halt_pc", int'(pc), 5);
        wait_cyc(48); chk("t3_still_halted", int'(halted), 1);
        chk("t3_still_pc", int'(pc), 5);
        chk("t3_sb_empty", sb.size(), 0);

        // Reset during EXEC of ADD r1,r1
        load_rom(16'h0000);
        rom[0] = 16'h2210;
        do_reset();
        wait_cyc(3);
        chk("t4_exec_raddr_a", int'(rf_raddr_a), 1);
        rst = 1'b1;
        #1;
        chk("t4_reset_outputs", outs(), 0);
        sb.push_back(mk(4, 1, 0, 3'd1, 0, 8'h10, 0, 3'd1, 3'd1, 4'd0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t4_refetch_addr", int'(rom_addr), 0);
        wait_cyc(5); chk("t4_pc_after_add", int'(pc), 1);
        chk("t4_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
